phase_sequencer: RTL and testbench

Parametrised instruction-phase sequencer for the multi-cycle core. Drives one-hot phase strobes (read, fetch, decode, execute, or any NUM_PHASES split) with a programmable per-phase cycle length, run/single-step control and hold (stall) support. Sits between the core control unit and the datapath stage enables. Replaces the fixed-count phase generator.

---
 rtl/phase_seq_pkg.sv | 20 ++
 rtl/phase_timer.sv | 48 ++++
 rtl/phase_sequencer.sv | 101 ++++++++++
 tb/tb_phase_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the instruction-phase sequencer.
// Covers the sequencer state encoding, effective phase length and index width.
package phase_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } seqState_t;

  // A programmed length of zero still occupies one cycle.
  function automatic int unsigned lenEff(input int unsigned field);
    return (field == 0) ? 1 : field;
  endfunction

  function automatic int idxWidth(input int numPhases);
    return (numPhases > 2) ? $clog2(numPhases) : 1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle timer: sub-count register, shadow copy of the phase lengths
// and the first/last-cycle decode for the currently active phase.
module phase_timer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 4,
  parameter int IDX_W      = idxWidth(NUM_PHASES)
) (
  input  logic                        Clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        active,
  input  logic                        hold,
  input  logic [IDX_W-1:0]            phaseIdx,
  input  logic [NUM_PHASES*CNT_W-1:0] phaseLen,
  output logic                        phaseFirst,
  output logic                        phaseLast,
  output logic                        advance
);

  logic [CNT_W-1:0]            subCnt;
  logic [CNT_W-1:0]            curField;
  logic [CNT_W-1:0]            lastCnt;
  logic [NUM_PHASES*CNT_W-1:0] shadowLen;

  // Lengths come from the shadow copy so mid-instruction rewrites of
  // phaseLen only take effect at the next instruction start.
  assign curField   = shadowLen[phaseIdx*CNT_W +: CNT_W];
  assign lastCnt    = CNT_W'(lenEff(32'(curField)) - 1);
  assign phaseFirst = active && (subCnt == '0);
  assign phaseLast  = active && (subCnt == lastCnt);
  assign advance    = phaseLast && !hold;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (rst) begin
      subCnt    <= '0;
      shadowLen <= '0;
    end else if (load) begin
      subCnt    <= '0;
      shadowLen <= phaseLen;
    end else if (active && !hold) begin
      subCnt <= phaseLast ? '0 : subCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer: RUN/STEP control FSM, phase index, one-hot
// phase strobes and retired-instruction counter around a phase_timer.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 4,
  parameter int ICNT_W     = 16
) (
  input  logic                              Clk,
  input  logic                              rst,
  input  logic                              run_en,
  input  logic                              step_req,
  input  logic                              hold,
  input  logic [NUM_PHASES*CNT_W-1:0]       phase_len,
  output logic [NUM_PHASES-1:0]             phase_oh,
  output logic [idxWidth(NUM_PHASES)-1:0]   phase_idx,
  output logic                              phase_first,
  output logic                              phase_last,
  output logic                              instr_done,
  output logic                              busy,
  output logic [ICNT_W-1:0]                 instr_count
);

  localparam int               IDX_W      = idxWidth(NUM_PHASES);
  localparam logic [IDX_W-1:0] LAST_PHASE = IDX_W'(NUM_PHASES - 1);

  seqState_t        state, nextState;
  logic [IDX_W-1:0] phaseIdx, nextIdx;
  logic             start;
  logic             active;
  logic             advance;

  assign active     = (state != IDLE);
  assign instr_done = phase_last && (phaseIdx == LAST_PHASE) && !hold;
  assign phase_idx  = phaseIdx;

  // Reload at every boundary so a back-to-back RUN instruction sees fresh lengths.
  phase_timer #(
    .NUM_PHASES(NUM_PHASES),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
  ) u_timer (
    .Clk       (Clk),
    .rst       (rst),
    .load      (start || instr_done),
    .active    (active),
    .hold      (hold),
    .phaseIdx  (phaseIdx),
    .phaseLen  (phase_len),
    .phaseFirst(phase_first),
    .phaseLast (phase_last),
    .advance   (advance)
  );

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    nextState = state;
    start     = 1'b0;
    unique case (state)
      IDLE: begin
        if (run_en) begin
          nextState = RUN;
          start     = 1'b1;
        end else if (step_req) begin
          nextState = STEP;
          start     = 1'b1;
        end
      end
      RUN, STEP: begin
        // Both modes drain to the boundary; run_en alone picks what follows.
        if (instr_done) nextState = run_en ? RUN : IDLE;
      end
      default: nextState = IDLE;
    endcase

    nextIdx = phaseIdx;
    if (start) begin
      nextIdx = '0;
    end else if (advance) begin
      nextIdx = (phaseIdx == LAST_PHASE) ? '0 : phaseIdx + IDX_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      state       <= IDLE;
      phaseIdx    <= '0;
      phase_oh    <= '0;
      busy        <= 1'b0;
      instr_count <= '0;
    end else begin
      state    <= nextState;
      phaseIdx <= nextIdx;
      busy     <= (nextState != IDLE);
      phase_oh <= (nextState != IDLE) ? (NUM_PHASES'(1) << nextIdx) : '0;
      if (instr_done) instr_count <= instr_count + ICNT_W'(1);
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: vector table, directed corner
// sequences and randomized traffic against a cycle-position reference model.
module tb_phase_sequencer;

  localparam int NP = 4;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_en = 1'b0;
  logic          step_req = 1'b0;
  logic          hold = 1'b0;
  logic [15:0]   phase_len = 16'h1212;
  logic [3:0]    phase_oh;
  logic [1:0]    phase_idx;
  logic          phase_first;
  logic          phase_last;
  logic          instr_done;
  logic          busy;
  logic [15:0]   instr_count;

  phase_sequencer #(.NUM_PHASES(NP), .CNT_W(CW), .ICNT_W(16)) dut (
    .Clk        (Clk),
    .rst        (rst),
    .run_en     (run_en),
    .step_req   (step_req),
    .hold       (hold),
    .phase_len  (phase_len),
    .phase_oh   (phase_oh),
    .phase_idx  (phase_idx),
    .phase_first(phase_first),
    .phase_last (phase_last),
    .instr_done (instr_done),
    .busy       (busy),
    .instr_count(instr_count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0]  oh;
    logic [1:0]  idx;
    logic        first;
    logic        last;
    logic        done;
    logic        busy;
    logic [15:0] cnt;
  } outs_t;

  typedef struct {
    bit          rst;
    bit          run;
    logic [3:0]  oh;
    bit          f;
    bit          l;
    bit          d;
    bit          b;
    logic [15:0] cnt;
  } vec_t;

  int    nChecks = 0;
  int    nFail   = 0;
  bit    modelOn = 1'b0;
  outs_t smp;

  // Reference model: position within the instruction in active cycles,
  // with phases found from running sums of the latched lengths.
  bit mBusy = 1'b0;
  int mT = 0;
  int mCount = 0;
  int mLen[NP] = '{1, 1, 1, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lenOf(input int f);
    return (f == 0) ? 1 : f;
  endfunction

  function automatic outs_t modelOut(input bit h);
    outs_t o;
    int acc;
    o = '0;
    o.cnt = 16'(mCount);
    o.busy = mBusy;
    acc = 0;
    if (mBusy) begin
      for (int i = 0; i < NP; i++) begin
        if (mT >= acc && mT < acc + mLen[i]) begin
          o.oh    = 4'(1 << i);
          o.idx   = 2'(i);
          o.first = (mT == acc);
          o.last  = (mT == acc + mLen[i] - 1);
          o.done  = o.last && (i == NP - 1) && !h;
        end
        acc += mLen[i];
      end
    end
    return o;
  endfunction

  task automatic modelLatch();
    for (int i = 0; i < NP; i++) mLen[i] = lenOf(int'(phase_len[i*CW +: CW]));
  endtask

  task automatic modelStep(input bit r, input bit s, input bit h, input bit rs);
    int total;
    total = 0;
    for (int i = 0; i < NP; i++) total += mLen[i];
    if (rs) begin
      mBusy = 1'b0;
      mT = 0;
      mCount = 0;
    end else if (!mBusy) begin
      if (r || s) begin
        mBusy = 1'b1;
        mT = 0;
        modelLatch();
      end
    end else if (!h) begin
      if (mT == total - 1) begin
        mCount = (mCount + 1) % 65536;
        if (r) begin
          mT = 0;
          modelLatch();
        end else begin
          mBusy = 1'b0;
          mT = 0;
        end
      end else begin
        mT++;
      end
    end
  endtask

  // Inputs are held for one full cycle; outputs sampled at the falling edge.
  task automatic cycle(input bit r, input bit s, input bit h, input bit rs);
    run_en = r;
    step_req = s;
    hold = h;
    rst = rs;
    @(negedge Clk);
    smp = {phase_oh, phase_idx, phase_first, phase_last, instr_done, busy, instr_count};
    if (modelOn) check("model", 32'(smp), 32'(modelOut(h)));
    @(posedge Clk);
    modelStep(r, s, h, rs);
    #1;
  endtask

  function automatic vec_t mk(input bit rs, input bit r, input logic [3:0] oh,
                              input bit f, input bit l, input bit d, input bit b,
                              input logic [15:0] cnt);
    vec_t v;
    v.rst = rs; v.run = r; v.oh = oh; v.f = f; v.l = l; v.d = d; v.b = b; v.cnt = cnt;
    return v;
  endfunction

  vec_t  tbl[15];
  outs_t snap;
  int    act, dones, dA, dB, c0;
  bit    found, runLvl;

  initial begin
    // Lengths {2,1,2,1}: a 6-cycle instruction, back to back while run_en is high.
    tbl[0]  = mk(0, 1, 4'b0000, 0, 0, 0, 0, 16'd0);
    tbl[1]  = mk(0, 1, 4'b0001, 1, 0, 0, 1, 16'd0);
    tbl[2]  = mk(0, 1, 4'b0001, 0, 1, 0, 1, 16'd0);
    tbl[3]  = mk(0, 1, 4'b0010, 1, 1, 0, 1, 16'd0);
    tbl[4]  = mk(0, 1, 4'b0100, 1, 0, 0, 1, 16'd0);
    tbl[5]  = mk(0, 1, 4'b0100, 0, 1, 0, 1, 16'd0);
    tbl[6]  = mk(0, 1, 4'b1000, 1, 1, 1, 1, 16'd0);
    tbl[7]  = mk(0, 1, 4'b0001, 1, 0, 0, 1, 16'd1);
    tbl[8]  = mk(0, 1, 4'b0001, 0, 1, 0, 1, 16'd1);
    tbl[9]  = mk(0, 1, 4'b0010, 1, 1, 0, 1, 16'd1);
    tbl[10] = mk(0, 1, 4'b0100, 1, 0, 0, 1, 16'd1);
    tbl[11] = mk(0, 1, 4'b0100, 0, 1, 0, 1, 16'd1);
    tbl[12] = mk(0, 1, 4'b1000, 1, 1, 1, 1, 16'd1);
    tbl[13] = mk(1, 1, 4'b0001, 1, 0, 0, 1, 16'd2);
    tbl[14] = mk(0, 0, 4'b0000, 0, 0, 0, 0, 16'd0);

    @(posedge Clk);
    @(posedge Clk);
    #1;
    modelStep(0, 0, 0, 1);
    modelOn = 1'b1;
    cycle(0, 0, 0, 1);
    check("reset_values", 32'(smp), 32'd0);

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].run, 0, 0, tbl[i].rst);
      check($sformatf("tbl_row%0d", i),
            32'({smp.oh, smp.first, smp.last, smp.done, smp.busy, smp.cnt}),
            32'({tbl[i].oh, tbl[i].f, tbl[i].l, tbl[i].d, tbl[i].b, tbl[i].cnt}));
    end

    // Single step, with a second step_req mid-instruction that must be ignored.
    act = 0;
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, i == 2, 0, 0);
      if (smp.busy) act++;
    end
    check("step_active_cycles", 32'(act), 32'd6);
    check("step_count", 32'(smp.cnt), 32'd1);
    check("step_idle_after", 32'({smp.busy, smp.oh}), 32'd0);

    // Three hold cycles at the start of phase 2 stretch the instruction to 9.
    act = 0;
    dones = 0;
    snap = '0;
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 15; i++) begin
      cycle(0, 0, (i >= 3 && i < 6), 0);
      if (smp.busy) act++;
      if (smp.done) dones++;
      if (i == 3) snap = smp;
      if (i == 4 || i == 5) check($sformatf("hold_frozen_%0d", i), 32'(smp), 32'(snap));
    end
    check("hold_phase2", 32'({snap.oh, snap.idx, snap.first, snap.done}), 32'({4'b0100, 2'd2, 1'b1, 1'b0}));
    check("hold_active_cycles", 32'(act), 32'd9);
    check("hold_single_done", 32'(dones), 32'd1);
    check("hold_count", 32'(smp.cnt), 32'd2);

    // Zero lengths act as 1; a mid-instruction rewrite waits for the boundary.
    phase_len = 16'h0000;
    dA = -1;
    dB = -1;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) phase_len = 16'h3333;
      cycle(1, 0, 0, 0);
      if (smp.done) begin
        if (dA < 0) dA = i;
        else if (dB < 0) dB = i;
      end
    end
    check("zero_len_done_cycle", 32'(dA), 32'd4);
    check("relatched_len_done_cycle", 32'(dB), 32'd16);

    // Drop run_en in phase 1 and pulse step_req while still running.
    phase_len = 16'h1212;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1, 0, 0, 0);
      if (smp.oh == 4'b0010) found = 1'b1;
    end
    check("reach_phase1", 32'(found), 32'd1);
    c0 = int'(smp.cnt);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 0, 0);
      if (!smp.busy) break;
    end
    check("drain_idle", 32'({smp.busy, smp.oh}), 32'd0);
    check("drain_count", 32'(smp.cnt), 32'((c0 + 1) % 65536));
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("step_not_queued", 32'({smp.busy, smp.cnt}), 32'({1'b0, 16'((c0 + 1) % 65536)}));

    // Reset with hold asserted in the middle of phase 2.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1, 0, 0, 0);
      if (smp.oh == 4'b0100) found = 1'b1;
    end
    check("reach_phase2", 32'(found), 32'd1);
    cycle(1, 0, 1, 1);
    cycle(0, 0, 0, 0);
    check("rst_mid_instr", 32'(smp), 32'd0);

    // Randomized traffic; run_en is held for random stretches so both RUN and STEP occur.
    runLvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) phase_len = 16'($urandom);
      if ($urandom_range(0, 19) == 0) runLvl = ~runLvl;
      cycle(runLvl, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
